// File: rtl/cache_mem_requester_if.sv
`default_nettype none
// ============================================================================
// cache_mem_requester_if : CPU-side request/response and memory block bus
// Rev 1.0
// ============================================================================
interface cache_mem_requester_if #(
   parameter int BLOCK_SIZE = 8,
   parameter int ADDR_W     = 16
);
   localparam int OFF_W = $clog2(BLOCK_SIZE);

   logic                      cpu_req_valid;
   logic                      cpu_write;
   logic [ADDR_W-1:0]         cpu_addr;
   logic [7:0]                cpu_wdata;
   logic                      cpu_ready;
   logic                      cpu_resp_valid;
   logic [7:0]                cpu_rdata;

   logic                      mem_req_valid;
   logic                      mem_write;
   logic [ADDR_W-OFF_W-1:0]   mem_addr;
   logic [BLOCK_SIZE*8-1:0]   mem_data_out;
   logic [BLOCK_SIZE*8-1:0]   mem_data_in;
   logic                      mem_ready;

   modport master (
      input  cpu_req_valid, cpu_write, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_resp_valid, cpu_rdata,
      output mem_req_valid, mem_write, mem_addr, mem_data_out,
      input  mem_data_in, mem_ready
   );

   modport slave (
      output cpu_req_valid, cpu_write, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_resp_valid, cpu_rdata,
      input  mem_req_valid, mem_write, mem_addr, mem_data_out,
      output mem_data_in, mem_ready
   );
endinterface
`default_nettype wire

// File: rtl/cache_mem_requester.sv
`default_nettype none
// ============================================================================
// cache_mem_requester : direct-mapped write-back write-allocate cache controller
// Rev 1.0
// ============================================================================
module cache_mem_requester #(
   parameter int BLOCK_SIZE = 8,
   parameter int NUM_LINES  = 16,
   parameter int ADDR_W     = 16
) (
   input  wire logic               clk,
   input  wire logic               rst,
   cache_mem_requester_if.master   bus
);
   localparam int OFF_W  = $clog2(BLOCK_SIZE);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int BLK_W  = ADDR_W - OFF_W;
   localparam int LINE_W = BLOCK_SIZE * 8;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] LOOKUP    = 3'd1;
   localparam logic [2:0] WB_REQ    = 3'd2;
   localparam logic [2:0] WB_WAIT   = 3'd3;
   localparam logic [2:0] FILL_REQ  = 3'd4;
   localparam logic [2:0] FILL_WAIT = 3'd5;
   localparam logic [2:0] RESP      = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              seen_busy_q, seen_busy_d;
   logic              mem_write_q, mem_write_d;
   logic [BLK_W-1:0]  mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_data_out_q, mem_data_out_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [NUM_LINES-1:0] dirty_q, dirty_d;
   logic [TAG_W-1:0]  tag_q  [NUM_LINES];
   logic [TAG_W-1:0]  tag_d  [NUM_LINES];
   logic [LINE_W-1:0] data_q [NUM_LINES];
   logic [LINE_W-1:0] data_d [NUM_LINES];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [OFF_W-1:0]  off;
   logic [LINE_W-1:0] cur_line;
   logic [7:0]        cur_byte;
   logic              hit;

   assign idx      = addr_q[OFF_W +: IDX_W];
   assign tag      = addr_q[ADDR_W-1 -: TAG_W];
   assign off      = addr_q[OFF_W-1:0];
   assign cur_line = data_q[idx];
   assign cur_byte = cur_line[{off, 3'b000} +: 8];
   assign hit      = valid_q[idx] && (tag_q[idx] == tag);

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      write_d        = write_q;
      wdata_d        = wdata_q;
      seen_busy_d    = seen_busy_q;
      mem_write_d    = mem_write_q;
      mem_addr_d     = mem_addr_q;
      mem_data_out_d = mem_data_out_q;
      valid_d        = valid_q;
      dirty_d        = dirty_q;
      tag_d          = tag_q;
      data_d         = data_q;
      case (state_q)
         IDLE: begin
            if (bus.cpu_req_valid) begin
               addr_d  = bus.cpu_addr;
               write_d = bus.cpu_write;
               wdata_d = bus.cpu_wdata;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            // Request fields are loaded on entry so they are stable for the whole transaction
            if (hit) begin
               state_d = RESP;
            end else if (valid_q[idx] && dirty_q[idx]) begin
               mem_write_d    = 1'b1;
               mem_addr_d     = {tag_q[idx], idx};
               mem_data_out_d = cur_line;
               state_d        = WB_REQ;
            end else begin
               mem_write_d = 1'b0;
               mem_addr_d  = addr_q[ADDR_W-1:OFF_W];
               state_d     = FILL_REQ;
            end
         end
         WB_REQ: begin
            if (bus.mem_ready) begin
               seen_busy_d = 1'b0;
               state_d     = WB_WAIT;
            end
         end
         WB_WAIT: begin
            if (!bus.mem_ready) begin
               seen_busy_d = 1'b1;
            end else if (seen_busy_q) begin
               dirty_d[idx] = 1'b0;
               mem_write_d  = 1'b0;
               mem_addr_d   = addr_q[ADDR_W-1:OFF_W];
               state_d      = FILL_REQ;
            end
         end
         FILL_REQ: begin
            if (bus.mem_ready) begin
               seen_busy_d = 1'b0;
               state_d     = FILL_WAIT;
            end
         end
         FILL_WAIT: begin
            if (!bus.mem_ready) begin
               seen_busy_d = 1'b1;
            end else if (seen_busy_q) begin
               data_d[idx]  = bus.mem_data_in;
               tag_d[idx]   = tag;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = 1'b0;
               state_d      = LOOKUP;
            end
         end
         RESP: begin
            if (write_q) begin
               data_d[idx][{off, 3'b000} +: 8] = wdata_q;
               dirty_d[idx] = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         write_q        <= 1'b0;
         wdata_q        <= '0;
         seen_busy_q    <= 1'b0;
         mem_write_q    <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_out_q <= '0;
         valid_q        <= '0;
         dirty_q        <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         write_q        <= write_d;
         wdata_q        <= wdata_d;
         seen_busy_q    <= seen_busy_d;
         mem_write_q    <= mem_write_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_out_q <= mem_data_out_d;
         valid_q        <= valid_d;
         dirty_q        <= dirty_d;
      end
   end

   // Tag and data storage need no reset; the valid bits qualify them
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign bus.cpu_ready      = !rst && (state_q == IDLE);
   assign bus.cpu_resp_valid = !rst && (state_q == RESP);
   assign bus.cpu_rdata      = (!rst && (state_q == RESP) && !write_q) ? cur_byte : 8'h00;
   assign bus.mem_req_valid  = !rst && bus.mem_ready &&
                               ((state_q == WB_REQ) || (state_q == FILL_REQ));
   assign bus.mem_write      = mem_write_q;
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_data_out   = mem_data_out_q;
endmodule
`default_nettype wire
